// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Bundle between the multicycle controller and its datapath.
//               It carries the instruction fields and the ALU zero flag into
//               the controller, and the datapath enables, the mux selects,
//               the ALU operation, the illegal flag and the debug state out
//               of the controller.
//               master : controller side
//               slave  : datapath side
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
    logic [6:0] opcode;       // inst[6:0]
    logic [2:0] funct3;       // inst[14:12]
    logic       funct7_5;     // inst[30]
    logic       zero;         // ALU zero flag, same cycle
    logic       PCWrite;      // PC load enable, branch term folded in
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       PCSource;
    logic [1:0] ALUSrcB;      // 00 B, 01 constant 4, 10 immediate
    logic [3:0] alu_control;  // 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
    logic       illegal;      // sticky unsupported-instruction flag
    logic [3:0] state;        // debug view of the current state

    modport master (
        input  opcode, funct3, funct7_5, zero,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
               ALUSrcA, PCSource, ALUSrcB, alu_control, illegal, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
               ALUSrcA, PCSource, ALUSrcB, alu_control, illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore-style control FSM for a multicycle RV32 subset
//               (lw, sw, R-type add/sub/and/or, I-type addi/andi/ori, beq).
//               Ports : clk   - rising-edge clock
//                       reset - synchronous, active-high
//                       bus   - multicycle_control_if.master (instruction
//                               fields and zero in; datapath controls out)
//               Option: CTRL_ILLEGAL_TRAP_EN - when defined, an unsupported
//                       instruction parks the FSM in HALT with illegal=1
//                       until reset. When undefined, it retires as a NOP
//                       and illegal is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        HALT      = 4'd10
    } state_t;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

    localparam logic [3:0] C_ALU_AND = 4'b0000;
    localparam logic [3:0] C_ALU_OR  = 4'b0001;
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_SUB = 4'b0110;

    // Where an unsupported instruction goes in the state it is detected.
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t C_ILLEGAL_NEXT = HALT;
`else
    localparam state_t C_ILLEGAL_NEXT = FETCH;
`endif

    state_t     r_state;
    state_t     w_next_state;

    logic       w_pc_write;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic       w_pc_source;
    logic [1:0] w_alu_src_b;
    logic [3:0] w_alu_control;

    logic [3:0] w_alu_r;
    logic       w_r_ok;
    logic [3:0] w_alu_i;
    logic       w_i_ok;

    // funct3/funct7 decode for the two ALU-execute states
    always_comb begin
        w_alu_r = C_ALU_ADD;
        w_r_ok  = 1'b1;
        case (bus.funct3)
            3'b000:  w_alu_r = bus.funct7_5 ? C_ALU_SUB : C_ALU_ADD;
            3'b111:  w_alu_r = C_ALU_AND;
            3'b110:  w_alu_r = C_ALU_OR;
            default: w_r_ok  = 1'b0;
        endcase

        w_alu_i = C_ALU_ADD;
        w_i_ok  = 1'b1;
        case (bus.funct3)
            3'b000:  w_alu_i = C_ALU_ADD;
            3'b111:  w_alu_i = C_ALU_AND;
            3'b110:  w_alu_i = C_ALU_OR;
            default: w_i_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = FETCH;
        w_pc_write    = 1'b0;
        w_iord        = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_pc_source   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_control = C_ALU_ADD;

        case (r_state)
            FETCH: begin
                // ALUOut <= PC + 4 while the instruction is loaded
                w_mem_read   = 1'b1;
                w_ir_write   = 1'b1;
                w_alu_src_b  = 2'b01;
                w_next_state = DECODE;
            end
            DECODE: begin
                // PC takes PC+4 from ALUOut; ALU forms the branch target
                w_pc_write  = 1'b1;
                w_pc_source = 1'b1;
                w_alu_src_b = 2'b10;
                case (bus.opcode)
                    C_OP_LOAD,
                    C_OP_STORE:  w_next_state = MEM_ADDR;
                    C_OP_RTYPE:  w_next_state = EXEC_R;
                    C_OP_ITYPE:  w_next_state = EXEC_I;
                    C_OP_BRANCH: w_next_state = BRANCH;
                    default:     w_next_state = C_ILLEGAL_NEXT;
                endcase
            end
            MEM_ADDR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_next_state = (bus.opcode == C_OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                w_iord       = 1'b1;
                w_mem_read   = 1'b1;
                w_next_state = MEM_WB;
            end
            MEM_WB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            EXEC_R: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = w_alu_r;
                w_next_state  = w_r_ok ? ALU_WB : C_ILLEGAL_NEXT;
            end
            EXEC_I: begin
                w_alu_src_a   = 1'b1;
                w_alu_src_b   = 2'b10;
                w_alu_control = w_alu_i;
                w_next_state  = w_i_ok ? ALU_WB : C_ILLEGAL_NEXT;
            end
            ALU_WB: begin
                w_reg_write = 1'b1;
            end
            BRANCH: begin
                // beq only: the PC loads the target computed in DECODE
                w_alu_src_a   = 1'b1;
                w_alu_control = C_ALU_SUB;
                w_pc_source   = 1'b1;
                w_pc_write    = bus.zero;
            end
            HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                w_next_state = HALT;
`else
                w_next_state = FETCH;
`endif
            end
            default: w_next_state = FETCH;
        endcase
    end

    // Reset is synchronous, so the state register may still hold a
    // mid-instruction state during the first reset cycle; the enables are
    // masked so no write escapes in that cycle.
    assign bus.PCWrite     = w_pc_write  & ~reset;
    assign bus.MemRead     = w_mem_read  & ~reset;
    assign bus.MemWrite    = w_mem_write & ~reset;
    assign bus.IRWrite     = w_ir_write  & ~reset;
    assign bus.RegWrite    = w_reg_write & ~reset;
    assign bus.IorD        = w_iord;
    assign bus.MemtoReg    = w_mem_to_reg;
    assign bus.ALUSrcA     = w_alu_src_a;
    assign bus.PCSource    = w_pc_source;
    assign bus.ALUSrcB     = w_alu_src_b;
    assign bus.alu_control = w_alu_control;
    assign bus.state       = r_state;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal = (r_state == HALT) & ~reset;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each scenario
//               pushes the expected per-cycle output word (state plus all
//               controls) into a queue and pops it as the DUT steps.
//               Honours CTRL_ILLEGAL_TRAP_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    logic [19:0] e_w;
    logic [19:0] o_w;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic [2:0] cur_f3  = 3'b000;
    logic       cur_f75 = 1'b0;
    logic       cur_z   = 1'b0;

    // Reference table of the control outputs for one state.
    // Word: {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
    //        RegWrite, ALUSrcA, ALUSrcB[1:0], alu_control[3:0], PCSource, illegal}
    function automatic logic [19:0] model(input logic [3:0] st, input logic z,
                                          input logic [2:0] f3, input logic f75,
                                          input logic rst);
        logic pcw, iord, mr, mw, irw, m2r, rw, asa, pcs, ill;
        logic [1:0] asb;
        logic [3:0] alu;
        pcw = 0; iord = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rw = 0;
        asa = 0; pcs = 0; ill = 0; asb = 2'b00; alu = 4'b0010;
        case (st)
            4'd0: begin mr = 1; irw = 1; asb = 2'b01; end
            4'd1: begin pcw = 1; pcs = 1; asb = 2'b10; end
            4'd2: begin asa = 1; asb = 2'b10; end
            4'd3: begin iord = 1; mr = 1; end
            4'd4: begin m2r = 1; rw = 1; end
            4'd5: begin iord = 1; mw = 1; end
            4'd6: begin
                asa = 1;
                if (f3 == 3'b000) alu = f75 ? 4'b0110 : 4'b0010;
                else if (f3 == 3'b111) alu = 4'b0000;
                else if (f3 == 3'b110) alu = 4'b0001;
            end
            4'd7: begin
                asa = 1; asb = 2'b10;
                if (f3 == 3'b111) alu = 4'b0000;
                else if (f3 == 3'b110) alu = 4'b0001;
            end
            4'd8: rw = 1;
            4'd9: begin asa = 1; alu = 4'b0110; pcs = 1; pcw = z; end
`ifdef CTRL_ILLEGAL_TRAP_EN
            4'd10: ill = 1;
`endif
            default: ;
        endcase
        if (rst) begin
            pcw = 0; mr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        end
        return {st, pcw, iord, mr, mw, irw, m2r, rw, asa, asb, alu, pcs, ill};
    endfunction

    function automatic logic [19:0] observe();
        return {bus.state, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.alu_control, bus.PCSource, bus.illegal};
    endfunction

    task automatic set_inputs(input logic [6:0] op, input logic [2:0] f3,
                              input logic f75, input logic z);
        bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75; bus.zero = z;
        cur_f3 = f3; cur_f75 = f75; cur_z = z;
    endtask

    task automatic push_state(input logic [3:0] st);
        exp_q.push_back(model(st, cur_z, cur_f3, cur_f75, 1'b0));
    endtask

    // Holds reset for n cycles; the first sampled cycle shows first_state.
    task automatic test_reset(input logic [3:0] first_state, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(model((i == 0) ? first_state : 4'd0, cur_z, cur_f3, cur_f75, 1'b1));
        for (int i = 0; i < n; i++) begin
            @(negedge clk); reset = 1'b1; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL reset cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
    endtask

    task automatic test_itype();
        set_inputs(OP_I, 3'b000, 1'b0, 1'b0);
        push_state(0); push_state(1); push_state(7); push_state(8);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL itype cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
    endtask

    task automatic test_lw();
        set_inputs(OP_LW, 3'b010, 1'b0, 1'b0);
        push_state(0); push_state(1); push_state(2); push_state(3); push_state(4);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL lw cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
    endtask

    task automatic test_sw();
        int mw_cycles;
        mw_cycles = 0;
        set_inputs(OP_SW, 3'b010, 1'b0, 1'b0);
        push_state(0); push_state(1); push_state(2); push_state(5);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            if (bus.MemWrite === 1'b1) mw_cycles++;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL sw cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
        checks++;
        if (mw_cycles !== 1) begin
            errors++;
            $display("FAIL sw_memwrite_count: got %0d expected 1", mw_cycles);
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            set_inputs(OP_BEQ, 3'b101, 1'b0, (k == 0));
            push_state(0); push_state(1); push_state(9);
            for (int i = 0; exp_q.size() > 0; i++) begin
                @(negedge clk); reset = 1'b0; #2;
                e_w = exp_q.pop_front(); o_w = observe(); checks++;
                if (o_w !== e_w) begin
                    errors++;
                    $display("FAIL beq zero=%0d cycle %0d: got %05h expected %05h",
                             cur_z, i, o_w, e_w);
                end
            end
        end
    endtask

    task automatic test_rtype();
        logic [3:0] f;
        for (int k = 0; k < 3; k++) begin
            f = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0111 : 4'b0110;
            set_inputs(OP_R, f[2:0], f[3], 1'b0);
            push_state(0); push_state(1); push_state(6); push_state(8);
            for (int i = 0; exp_q.size() > 0; i++) begin
                @(negedge clk); reset = 1'b0; #2;
                e_w = exp_q.pop_front(); o_w = observe(); checks++;
                if (o_w !== e_w) begin
                    errors++;
                    $display("FAIL rtype f3=%0d f7=%0d cycle %0d: got %05h expected %05h",
                             cur_f3, cur_f75, i, o_w, e_w);
                end
            end
        end
    endtask

    // lw aborted by a reset arriving while the DUT sits in MEM_READ
    task automatic test_reset_mid();
        set_inputs(OP_LW, 3'b010, 1'b0, 1'b0);
        push_state(0); push_state(1); push_state(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
        test_reset(4'd3, 2);
    endtask

    task automatic test_illegal_opcode();
        set_inputs(OP_LUI, 3'b000, 1'b0, 1'b0);
        push_state(0); push_state(1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) push_state(10);
`else
        push_state(0);
`endif
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL illegal_opcode cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        test_reset(4'd10, 2);
`else
        test_reset(4'd1, 2);
`endif
    endtask

    task automatic test_illegal_funct3();
        set_inputs(OP_R, 3'b001, 1'b0, 1'b0);
        push_state(0); push_state(1); push_state(6);
`ifdef CTRL_ILLEGAL_TRAP_EN
        push_state(10); push_state(10); push_state(10);
`else
        push_state(0);
`endif
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL illegal_funct3 cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        test_reset(4'd10, 2);
`else
        test_reset(4'd1, 2);
`endif
    endtask

    task automatic test_back_to_back();
        set_inputs(OP_I, 3'b110, 1'b0, 1'b0);
        push_state(0); push_state(1); push_state(7); push_state(8);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL b2b_ori cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
        set_inputs(OP_BEQ, 3'b000, 1'b0, 1'b1);
        push_state(0); push_state(1); push_state(9); push_state(0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk); reset = 1'b0; #2;
            e_w = exp_q.pop_front(); o_w = observe(); checks++;
            if (o_w !== e_w) begin
                errors++;
                $display("FAIL b2b_beq cycle %0d: got %05h expected %05h", i, o_w, e_w);
            end
        end
    endtask

    initial begin
        set_inputs(7'd0, 3'd0, 1'b0, 1'b0);
        test_reset(4'd0, 3);
        test_itype();
        test_lw();
        test_sw();
        test_branch();
        test_rtype();
        test_reset_mid();
        test_illegal_opcode();
        test_illegal_funct3();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, required end before 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock shared with the datapath registers.
REQ-003 reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 opcode  in  7  inst[6:0] from the instruction register.
REQ-005 funct3  in  3  inst[14:12] from the instruction register.
REQ-006 funct7_5  in  1  inst[30] from the instruction register.
REQ-007 zero  in  1  ALU zero flag, combinational in the current cycle.
REQ-008 PCWrite  out  1  PC load enable; the conditional branch term is already folded in.
REQ-009 IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource  out  1 each  datapath mux selects and enables.
REQ-010 ALUSrcB  out  2  B-input select: 00 = B, 01 = 4, 10 = immediate.
REQ-011 alu_control  out  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-012 illegal  out  1  sticky unsupported-instruction flag.
REQ-013 state  out  4  current state encoding, provided for debug.

Function
REQ-014 The block SHALL be a Moore FSM; outputs decode from state only, except PCWrite in BRANCH, which also depends on zero.
REQ-015 State encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, HALT=10. Encodings 11-15 SHALL go to FETCH.
REQ-016 Any output not listed for a state SHALL be 0, ALUSrcB SHALL be 00, and alu_control SHALL be 0010.
REQ-017 FETCH: IorD=0, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD (ALUOut <= PC+4); PC is not written. Next state is DECODE.
REQ-018 DECODE: PCWrite=1, PCSource=1 (PC <= PC+4), ALUSrcA=0, ALUSrcB=10, ADD (ALUOut <= old PC + imm). The next state depends on opcode:
- 0000011 or 0100011 -> MEM_ADDR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- any other opcode -> per REQ-027.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ADD. Next state is MEM_READ if opcode=0000011, otherwise MEM_WRITE.
REQ-020 MEM_READ: IorD=1, MemRead=1. Next state is MEM_WB.
REQ-021 MEM_WB: MemtoReg=1, RegWrite=1. Next state is FETCH.
REQ-022 MEM_WRITE: IorD=1, MemWrite=1. Next state is FETCH.
REQ-023 EXEC_R: ALUSrcA=1, ALUSrcB=00. alu_control decodes as:
- funct3 000 with funct7_5=0 -> 0010
- funct3 000 with funct7_5=1 -> 0110
- funct3 111 -> 0000
- funct3 110 -> 0001
- any other funct3 -> unsupported (REQ-027).
Next state is ALU_WB.
REQ-024 EXEC_I: ALUSrcA=1, ALUSrcB=10. funct3 000 -> 0010, 111 -> 0000, 110 -> 0001; any other funct3 is unsupported. Next state is ALU_WB.
REQ-025 ALU_WB: MemtoReg=0, RegWrite=1. Next state is FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, alu_control=0110, PCSource=1, PCWrite=zero; funct3 is ignored (beq only). Next state is FETCH.
REQ-027 Unsupported opcode, or unsupported funct3 in EXEC_R/EXEC_I, SHALL be handled per REQ-033/REQ-034, taking effect in the state where it is detected.
REQ-028 Cycles per instruction SHALL be: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3.
REQ-029 MemWrite and RegWrite SHALL each assert for at most one cycle per instruction.

Reset
REQ-030 While reset=1, all enables (PCWrite, MemRead, MemWrite, IRWrite, RegWrite) and illegal SHALL be 0, and state SHALL load FETCH.
REQ-031 A reset asserted in any state, including mid-instruction, SHALL abort the instruction with no further write.
REQ-032 After reset deasserts, the first cycle SHALL be FETCH.

Configuration
REQ-033 With CTRL_ILLEGAL_TRAP_EN defined, an unsupported instruction SHALL enter HALT. HALT holds all enables at 0, sets illegal=1, and stays in HALT until reset.
REQ-034 Without CTRL_ILLEGAL_TRAP_EN, an unsupported instruction SHALL go to FETCH with no register or memory write (NOP), and illegal SHALL be tied to 0; HALT is unreachable.

Verification
REQ-035 Reset held 3 cycles, then opcode=0010011, funct3=000 -> state sequence 0,1,7,8,0; alu_control=0010 in EXEC_I; RegWrite=1 only in ALU_WB.
REQ-036 opcode=0000011 -> sequence 0,1,2,3,4,0; IorD=1 and MemRead=1 in state 3; MemtoReg=1 and RegWrite=1 in state 4; reset asserted in state 3 -> next state 0 with no RegWrite.
REQ-037 opcode=0100011 -> sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle with IorD=1.
REQ-038 opcode=1100011: zero=1 in BRANCH -> PCWrite=1 and PCSource=1; zero=0 -> PCWrite=0; both cases return to FETCH after 3 cycles.
REQ-039 opcode=0110011 in EXEC_R: funct3=000 with funct7_5=1 -> 0110; funct3=111 -> 0000; funct3=110 -> 0001.
REQ-040 opcode=0110111: with the macro -> state 10, illegal=1, enables 0 for 20 cycles until reset; without the macro -> state 0 after DECODE, illegal=0.
